// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares one single-port synchronous RAM between an SPI slave command
//   stream and a local host requester. Only one RAM access is in flight
//   at a time. When both sides are waiting, the side that was not served
//   last is served next.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   spi_rx_data/valid       10-bit SPI word {cmd[1:0], payload}
//                           00 = set wr_addr, 10 = set rd_addr,
//                           01 = write payload, 11 = read
//   spi_tx_data/valid       read data returned to the SPI slave (strobe)
//   spi_ovf                 pulse: an SPI access was dropped (one already pending)
//   host_req/we/addr/wdata  host request; held stable until host_gnt
//   host_gnt                pulse: the host access is on the RAM this cycle
//   host_rdata/rvalid       read data returned to the host (strobe)
//   ram_en/we/addr/wdata    RAM controls, all registered
//   ram_rdata               RAM read data, valid the cycle after a read
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [DATA_SIZE-1:0] spi_tx_data,
    output logic                 spi_tx_valid,
    output logic                 spi_ovf,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic [DATA_SIZE-1:0] host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0] ram_wdata,
    input  logic [DATA_SIZE-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RD_WAIT = 2'd2} state_t;
    typedef enum logic {GRANT_HOST = 1'b0, GRANT_SPI = 1'b1} grant_t;

    // Command bit 0 marks a RAM access; bit 1 selects the read side.
    logic [1:0]           spi_cmd;
    logic [ADDR_SIZE-1:0] spi_payload;
    logic                 spi_access;

    assign spi_cmd     = spi_rx_data[ADDR_SIZE+1:ADDR_SIZE];
    assign spi_payload = spi_rx_data[ADDR_SIZE-1:0];
    assign spi_access  = spi_rx_valid & spi_cmd[0];

    state_t               state, state_d;
    grant_t               last_grant, owner, owner_d, winner;
    logic                 spi_pend, pend_we, clear_pend;
    logic [ADDR_SIZE-1:0] pend_addr, wr_addr, rd_addr;
    logic [DATA_SIZE-1:0] pend_data;

    logic                 ram_en_d, ram_we_d, host_gnt_d;
    logic [ADDR_SIZE-1:0] ram_addr_d;
    logic [DATA_SIZE-1:0] ram_wdata_d;
    logic                 spi_tx_valid_d, host_rvalid_d;
    logic [DATA_SIZE-1:0] spi_tx_data_d, host_rdata_d;

    // Next-state and next-output logic.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        winner         = (spi_pend && (!host_req || last_grant == GRANT_HOST))
                         ? GRANT_SPI : GRANT_HOST;
        state_d        = state;
        owner_d        = owner;
        clear_pend     = 1'b0;
        ram_en_d       = 1'b0;
        ram_we_d       = 1'b0;
        ram_addr_d     = ram_addr;
        ram_wdata_d    = ram_wdata;
        host_gnt_d     = 1'b0;
        spi_tx_valid_d = 1'b0;
        spi_tx_data_d  = spi_tx_data;
        host_rvalid_d  = 1'b0;
        host_rdata_d   = host_rdata;

        unique case (state)
            IDLE: begin
                if (spi_pend || host_req) begin
                    // Controls are registered here so the RAM sees them in ACCESS.
                    owner_d  = winner;
                    ram_en_d = 1'b1;
                    if (winner == GRANT_SPI) begin
                        ram_we_d    = pend_we;
                        ram_addr_d  = pend_addr;
                        ram_wdata_d = pend_data;
                    end else begin
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                        host_gnt_d  = 1'b1;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                clear_pend = (owner == GRANT_SPI);
                state_d    = ram_we ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                // Data goes back only to the side that issued the read.
                if (owner == GRANT_SPI) begin
                    spi_tx_data_d  = ram_rdata;
                    spi_tx_valid_d = 1'b1;
                end else begin
                    host_rdata_d  = ram_rdata;
                    host_rvalid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state, ownership and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= GRANT_HOST;
            last_grant   <= GRANT_HOST;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            host_gnt     <= 1'b0;
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
        end else begin
            state        <= state_d;
            owner        <= owner_d;
            if (ram_en_d) last_grant <= owner_d;
            ram_en       <= ram_en_d;
            ram_we       <= ram_we_d;
            ram_addr     <= ram_addr_d;
            ram_wdata    <= ram_wdata_d;
            host_gnt     <= host_gnt_d;
            spi_tx_data  <= spi_tx_data_d;
            spi_tx_valid <= spi_tx_valid_d;
            host_rdata   <= host_rdata_d;
            host_rvalid  <= host_rvalid_d;
        end
    end

    // SPI command decode: address latches, the single pending access, overflow.
    // The pending access snapshots its address at the strobe, so later
    // address commands cannot retarget it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_pend  <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            spi_ovf   <= 1'b0;
        end else begin
            spi_ovf <= spi_access & spi_pend;
            if (clear_pend) begin
                spi_pend <= 1'b0;
            end else if (spi_access && !spi_pend) begin
                spi_pend  <= 1'b1;
                pend_we   <= ~spi_cmd[1];
                pend_addr <= spi_cmd[1] ? rd_addr : wr_addr;
                pend_data <= DATA_SIZE'(spi_payload);
            end
            if (spi_rx_valid && !spi_cmd[0]) begin
                if (spi_cmd[1]) rd_addr <= spi_payload;
                else            wr_addr <= spi_payload;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter
//   Directed stimulus with literal expectations, plus a cycle-timeline model:
//   each grant decision schedules the RAM access one cycle later and the read
//   return three cycles later, and a shadow memory supplies read data.
//   A negedge compare process checks DUT outputs against that timeline.
module tb_spi_ram_arbiter;

    localparam int CMAX = 4100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid, spi_ovf;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       host_gnt, host_rvalid;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'h00;

    spi_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_ovf(spi_ovf),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM: synchronous write, 1-cycle synchronous read.
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    logic       e_en [CMAX], e_we [CMAX], e_gnt [CMAX], e_txv [CMAX], e_hrv [CMAX], e_ovf [CMAX];
    logic [7:0] e_addr [CMAX], e_wdata [CMAX], e_txd [CMAX], e_hrd [CMAX];
    logic [7:0] shadow [256];
    int         cyc = 0;
    bit         m_pend, m_pwe, m_last_spi;
    logic [7:0] m_paddr, m_pdata, m_wa, m_ra;
    int         m_idle_at, m_clear_at;

    task automatic clear_expect();
        for (int i = 0; i < CMAX; i++) begin
            e_en[i] = 0; e_we[i] = 0; e_gnt[i] = 0; e_txv[i] = 0; e_hrv[i] = 0; e_ovf[i] = 0;
            e_addr[i] = 0; e_wdata[i] = 0; e_txd[i] = 0; e_hrd[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        clear_expect();
    end

    // Inputs seen during cycle c decide what the DUT shows in cycles c+1..c+3.
    task automatic model_step(input int c);
        bit         acc, pend_now, spi_wins, we;
        logic [7:0] a, d, pl;
        pl = spi_rx_data[7:0];
        if (!rst_n) begin
            clear_expect();
            m_pend = 0; m_last_spi = 0; m_wa = 0; m_ra = 0;
            m_idle_at = c + 1; m_clear_at = -1;
            return;
        end
        acc      = spi_rx_valid && spi_rx_data[8];
        pend_now = m_pend;
        if (acc && pend_now) e_ovf[c+1] = 1;
        if (c >= m_idle_at && (pend_now || host_req)) begin
            spi_wins = pend_now && (!host_req || !m_last_spi);
            we = spi_wins ? m_pwe   : host_we;
            a  = spi_wins ? m_paddr : host_addr;
            d  = spi_wins ? m_pdata : host_wdata;
            e_en[c+1] = 1; e_we[c+1] = we; e_addr[c+1] = a; e_wdata[c+1] = d;
            e_gnt[c+1] = !spi_wins;
            m_last_spi = spi_wins;
            if (we) begin
                shadow[a] = d;
                m_idle_at = c + 2;
            end else begin
                m_idle_at = c + 3;
                if (spi_wins) begin e_txv[c+3] = 1; e_txd[c+3] = shadow[a]; end
                else          begin e_hrv[c+3] = 1; e_hrd[c+3] = shadow[a]; end
            end
            if (spi_wins) m_clear_at = c + 1;
        end
        if (c == m_clear_at) m_pend = 0;
        if (acc && !pend_now) begin
            m_pend  = 1;
            m_pwe   = !spi_rx_data[9];
            m_paddr = spi_rx_data[9] ? m_ra : m_wa;
            m_pdata = pl;
        end
        if (spi_rx_valid && !spi_rx_data[8]) begin
            if (spi_rx_data[9]) m_ra = pl;
            else                m_wa = pl;
        end
    endtask

    always @(posedge clk) begin
        model_step(cyc);
        cyc = cyc + 1;
    end

    // Compare process plus event counters used by the directed section.
    int n_ovf = 0, n_rd = 0, n_tx = 0, n_hrv = 0, n_spi_acc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {spi_tx_data, spi_tx_valid, spi_ovf, host_gnt, host_rdata,
                                    host_rvalid, ram_en, ram_we, ram_addr, ram_wdata}, 64'd0);
        end else begin
            check("m_ram_en", ram_en, e_en[cyc]);
            check("m_ram_we", ram_we, e_we[cyc]);
            if (e_en[cyc]) check("m_ram_addr", ram_addr, e_addr[cyc]);
            if (e_en[cyc] && e_we[cyc]) check("m_ram_wdata", ram_wdata, e_wdata[cyc]);
            check("m_host_gnt", host_gnt, e_gnt[cyc]);
            check("m_spi_tx_valid", spi_tx_valid, e_txv[cyc]);
            if (e_txv[cyc]) check("m_spi_tx_data", spi_tx_data, e_txd[cyc]);
            check("m_host_rvalid", host_rvalid, e_hrv[cyc]);
            if (e_hrv[cyc]) check("m_host_rdata", host_rdata, e_hrd[cyc]);
            check("m_spi_ovf", spi_ovf, e_ovf[cyc]);
            if (spi_ovf)                n_ovf++;
            if (ram_en && !ram_we)      n_rd++;
            if (spi_tx_valid)           n_tx++;
            if (host_rvalid)            n_hrv++;
            if (ram_en && !host_gnt)    n_spi_acc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_send(input logic [1:0] cmd, input logic [7:0] payload);
        spi_rx_data  = {cmd, payload};
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
    endtask

    task automatic host_read_chk(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        int k;
        host_req = 1'b1; host_we = 1'b0; host_addr = addr; host_wdata = 8'h00;
        k = 0;
        tick();
        while (!host_gnt && k < 20) begin tick(); k++; end
        check({tag, "_gnt"}, host_gnt, 1);
        host_req = 1'b0;
        k = 0;
        while (!host_rvalid && k < 10) begin tick(); k++; end
        check({tag, "_rvalid"}, host_rvalid, 1);
        check({tag, "_rdata"}, host_rdata, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s_ovf, s_rd, s_tx, s_hrv, s_spi;

    initial begin
        rst_n = 1'b0; spi_rx_data = '0; spi_rx_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) tick();
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_spi_tx_valid", spi_tx_valid, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // SPI write: 00/3C then 01/A5 -> RAM write 2 cycles after the 01 strobe.
        spi_send(2'b00, 8'h3C);
        spi_send(2'b01, 8'hA5);
        tick();
        check("wr_ram_en", ram_en, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 8'h3C);
        check("wr_ram_wdata", ram_wdata, 8'hA5);
        tick();
        check("wr_ram_en_drop", ram_en, 0);
        check("wr_ram_we_drop", ram_we, 0);
        repeat (8) tick();

        // SPI read: 10/3C then 11 -> spi_tx_valid with A5 exactly 4 cycles later.
        spi_send(2'b10, 8'h3C);
        repeat (9) tick();
        spi_send(2'b11, 8'h00);
        repeat (2) tick();
        check("rd_tx_valid_early", spi_tx_valid, 0);
        tick();
        check("rd_tx_valid", spi_tx_valid, 1);
        check("rd_tx_data", spi_tx_data, 8'hA5);
        tick();
        check("rd_tx_valid_one", spi_tx_valid, 0);
        repeat (6) tick();

        // Host write 0x10 = 5A: grant one cycle after the request.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
        tick();
        check("hw_gnt", host_gnt, 1);
        check("hw_ram_we", ram_we, 1);
        host_req = 1'b0;
        tick();
        // Host read 0x10: grant at H+1, data at H+3.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_wdata = 8'h00;
        tick();
        check("hr_gnt", host_gnt, 1);
        check("hr_ram_addr", ram_addr, 8'h10);
        host_req = 1'b0;
        tick();
        check("hr_rvalid_early", host_rvalid, 0);
        tick();
        check("hr_rvalid", host_rvalid, 1);
        check("hr_rdata", host_rdata, 8'h5A);
        repeat (3) tick();

        // SPI write 0x20 = C3 for the contention phase.
        spi_send(2'b00, 8'h20);
        repeat (9) tick();
        spi_send(2'b01, 8'hC3);
        repeat (9) tick();

        // Contention: host reads 0x10 continuously, SPI reads 0x20 every 11 cycles.
        s_tx = n_tx; s_spi = n_spi_acc; s_hrv = n_hrv;
        fork
            begin
                host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_wdata = 8'h00;
                repeat (60) tick();
                host_req = 1'b0;
            end
            begin
                spi_send(2'b10, 8'h20);
                repeat (9) tick();
                repeat (4) begin
                    spi_send(2'b11, 8'h00);
                    repeat (10) tick();
                end
            end
        join
        repeat (6) tick();
        check("cont_spi_tx_count", n_tx - s_tx, 4);
        check("cont_spi_access_count", n_spi_acc - s_spi, 4);
        check("cont_host_served", (n_hrv - s_hrv) > 10, 1);

        // Two SPI reads one cycle apart: one overflow, one read, one return.
        s_ovf = n_ovf; s_rd = n_rd; s_tx = n_tx;
        spi_send(2'b11, 8'h00);
        spi_send(2'b11, 8'h00);
        repeat (8) tick();
        check("ovf_pulses", n_ovf - s_ovf, 1);
        check("ovf_reads", n_rd - s_rd, 1);
        check("ovf_tx", n_tx - s_tx, 1);
        check("ovf_tx_data", spi_tx_data, 8'hC3);

        // Pending write must keep its address when wr_addr changes underneath.
        spi_send(2'b00, 8'h40);
        repeat (3) tick();
        spi_send(2'b01, 8'h11);
        spi_send(2'b00, 8'h77);
        check("pend_ram_en", ram_en, 1);
        check("pend_ram_addr", ram_addr, 8'h40);
        check("pend_ram_wdata", ram_wdata, 8'h11);
        repeat (3) tick();
        spi_send(2'b01, 8'h22);
        tick();
        check("newaddr_ram_addr", ram_addr, 8'h77);
        check("newaddr_ram_wdata", ram_wdata, 8'h22);
        repeat (4) tick();

        // Reset while a host read is in ACCESS.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_wdata = 8'h00;
        tick();
        check("rst_mid_gnt", host_gnt, 1);
        rst_n = 1'b0;
        host_req = 1'b0;
        #1;
        check("rst_mid_outputs", {spi_tx_data, spi_tx_valid, spi_ovf, host_gnt, host_rdata,
                                  host_rvalid, ram_en, ram_we, ram_addr, ram_wdata}, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        s_hrv = n_hrv; s_tx = n_tx;
        repeat (6) tick();
        check("rst_no_hrvalid", n_hrv - s_hrv, 0);
        check("rst_no_txvalid", n_tx - s_tx, 0);
        host_read_chk(8'h10, 8'h5A, "post_rst");
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Shares the single-port RAM between the SPI slave command stream and a local host requester. Decodes the 10-bit SPI word (2-bit command plus 8-bit payload) into address latches and RAM accesses. Arbitrates round-robin between SPI and host. Sequences the RAM's enable, write and 1-cycle synchronous read, and returns read data to the requester that issued the read.

## Interface
- ADDR_SIZE, 8, RAM address width
- DATA_SIZE, 8, RAM data width; SPI payload width equals ADDR_SIZE = DATA_SIZE

- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- spi_rx_data  in  10  [9:8] cmd, [7:0] payload
- spi_rx_valid  in  1  one-cycle strobe; spi_rx_data valid this cycle
- spi_tx_data  out  8  read data for SPI slave
- spi_tx_valid  out  1  one-cycle strobe with spi_tx_data
- spi_ovf  out  1  one-cycle pulse; SPI access command dropped
- host_req  in  1  level; host_we/addr/wdata held stable until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  DATA_SIZE  host write data
- host_gnt  out  1  one-cycle pulse; host access issued to RAM this cycle
- host_rdata  out  DATA_SIZE  host read data
- host_rvalid  out  1  one-cycle strobe with host_rdata
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_SIZE  RAM address
- ram_wdata  out  DATA_SIZE  RAM write data
- ram_rdata  in  DATA_SIZE  RAM read data, valid the cycle after a read with ram_en=1

## Operation
- SPI cmd decode on spi_rx_valid:
  - 00: wr_addr <= payload; no RAM access.
  - 10: rd_addr <= payload; no RAM access.
  - 01: set spi_pend, write of payload to wr_addr.
  - 11: set spi_pend, read of rd_addr; payload ignored.
- Address latches update on every 00/10, regardless of FSM state.
- spi_pend captures {we, addr, data} at the strobe. A later 00/10 does not alter a pending access.
- Command 01/11 arriving while spi_pend=1 is dropped. spi_ovf pulses in the following cycle; the pending access is unaffected.
- FSM states:
  - IDLE: if any request (spi_pend or host_req), choose a winner and register RAM controls -> ACCESS; else stay.
  - ACCESS: ram_en=1 with the winner's we/addr/wdata for exactly this cycle. Clears spi_pend (SPI winner) or pulses host_gnt (host winner). Read -> RD_WAIT; write -> IDLE.
  - RD_WAIT: capture ram_rdata into spi_tx_data or host_rdata. The matching valid is registered high in the next cycle. -> IDLE.
- Arbitration: last_grant register, reset value HOST. Single requester wins outright. On a tie, the requester not granted last wins. last_grant updates on each grant.
- One RAM access outstanding at a time; ram_en is never asserted in IDLE or RD_WAIT.
- ram_we=0 whenever ram_en=0; ram_addr/ram_wdata hold last value.

## Timing
- Reset (async assert, sync release by clk edge):
  - state=IDLE, spi_pend=0, last_grant=HOST, wr_addr=rd_addr=0.
  - All outputs 0: spi_tx_data, spi_tx_valid, spi_ovf, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr, ram_wdata.
- Reset mid-operation aborts any pending or in-flight access; no valid strobe follows.
- SPI read, spi_rx_valid in cycle T, uncontended:
  - spi_pend=1 in T+1 (IDLE decides).
  - ram_en=1 in T+2.
  - ram_rdata valid in T+3.
  - spi_tx_valid=1 in T+4.
- SPI write, uncontended: ram_en=ram_we=1 in T+2.
- Host, host_req first seen in IDLE at cycle H:
  - host_gnt=ram_en=1 in H+1.
  - Read: host_rvalid in H+3.
- Throughput: write occupies 2 cycles (IDLE, ACCESS); read occupies 3 (IDLE, ACCESS, RD_WAIT).
- Worst-case SPI service: a host read just granted plus own turn. SPI ram_en occurs by T+5; spi_tx_valid by T+7. This fits within the ≥10-cycle SPI word spacing, so spi_ovf never fires in legal traffic.
- Simultaneous spi_rx_valid (01/11) and host_req in IDLE: the SPI request is not yet pending, so the host wins that cycle.

## Test plan
- Reset, then SPI 00/0x3C, 01/0xA5 -> ram_en=ram_we=1, ram_addr=0x3C, ram_wdata=0xA5 exactly 2 cycles after the 01 strobe.
- SPI 10/0x3C, then 11/0x00, RAM model returns 0xA5 -> spi_tx_data=0xA5, spi_tx_valid one cycle, 4 cycles after the 11 strobe.
- host_req held continuously with read at 0x10, and SPI reads repeated every 11 cycles. Expected: grants alternate HOST/SPI; host_rvalid data and spi_tx_valid data each match their own addresses; no strobe is misrouted.
- Two SPI 11 commands 1 cycle apart -> spi_ovf pulses once, only one RAM read issued, one spi_tx_valid.
- SPI 01 pending, then 00/0x77 before service -> write lands at the earlier address, not 0x77.
- rst_n asserted in ACCESS of a read -> all outputs 0 immediately; no spi_tx_valid or host_rvalid after release; next host read is granted normally.
